// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader.
// Frame: SYNC, ADDR[4], LEN[2], DATA[4*LEN], CSUM.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    HUNT,
    ADDR,
    LEN,
    DATA,
    WAIT_ACK,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int ADDR_BYTES = 4;
  localparam int LEN_BYTES  = 2;

endpackage

// File: rtl/uart_boot_loader.sv
// Parses boot frames from the UART byte stream into RAM writes.
// Releases the core hold once a frame passes its checksum.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 5_000_000,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  output logic        o_cpu_hold,
  output logic        o_busy,
  output logic        o_err
);

  state_t      state;
  logic [7:0]  sum;
  logic [7:0]  sum_nx;
  logic [1:0]  idx;
  logic [15:0] cnt;
  logic [31:0] idle;
  logic        framing;
  logic        timeout;

  assign sum_nx  = sum + i_rx_data;
  assign framing = state inside {ADDR, LEN, DATA, CSUM};
  assign timeout = framing && !i_rx_valid &&
                   (idle == TIMEOUT_CYC - 1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= HUNT;
      sum         <= '0;
      idx         <= '0;
      cnt         <= '0;
      idle        <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_cpu_hold  <= 1'b1;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      if (i_rx_valid || !framing) idle <= '0;
      else                        idle <= idle + 32'd1;

      if (timeout) begin
        state  <= ERR;
        o_err  <= 1'b1;
        o_busy <= 1'b0;
      end else begin
        unique case (state)
          HUNT, ERR: begin
            if (i_rx_valid && i_rx_data == SYNC_BYTE) begin
              state  <= ADDR;
              sum    <= '0;
              idx    <= '0;
              o_err  <= 1'b0;
              o_busy <= 1'b1;
            end
          end
          ADDR: begin
            if (i_rx_valid) begin
              sum <= sum_nx;
              idx <= idx + 2'd1;
              o_mem_addr[{idx, 3'b000} +: 8] <= i_rx_data;
              if (idx == 2'(ADDR_BYTES - 1)) begin
                idx <= '0;
                // Low address bits arrived with the first byte.
                if (o_mem_addr[1:0] != 2'b00) begin
                  state  <= ERR;
                  o_err  <= 1'b1;
                  o_busy <= 1'b0;
                end else begin
                  state <= LEN;
                end
              end
            end
          end
          LEN: begin
            if (i_rx_valid) begin
              sum <= sum_nx;
              idx <= idx + 2'd1;
              cnt[{idx[0], 3'b000} +: 8] <= i_rx_data;
              if (idx == 2'(LEN_BYTES - 1)) begin
                idx <= '0;
                if ({i_rx_data, cnt[7:0]} == 16'd0)
                  state <= CSUM;
                else
                  state <= DATA;
              end
            end
          end
          DATA: begin
            if (i_rx_valid) begin
              sum <= sum_nx;
              idx <= idx + 2'd1;
              o_mem_wdata[{idx, 3'b000} +: 8] <= i_rx_data;
              if (idx == 2'd3) begin
                o_mem_we <= 1'b1;
                state    <= WAIT_ACK;
              end
            end
          end
          WAIT_ACK: begin
            if (i_rx_valid) begin
              state    <= ERR;
              o_mem_we <= 1'b0;
              o_err    <= 1'b1;
              o_busy   <= 1'b0;
            end else if (i_mem_ack) begin
              o_mem_we   <= 1'b0;
              o_mem_addr <= o_mem_addr + 32'd4;
              cnt        <= cnt - 16'd1;
              state      <= (cnt == 16'd1) ? CSUM : DATA;
            end
          end
          CSUM: begin
            if (i_rx_valid) begin
              o_busy <= 1'b0;
              if (sum_nx == 8'd0) begin
                state      <= DONE;
                o_cpu_hold <= 1'b0;
              end else begin
                state <= ERR;
                o_err <= 1'b1;
              end
            end
          end
          DONE: begin
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader.
// Frame-level reference model over byte arrays.
module tb_uart_boot_loader;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic        o_cpu_hold;
  logic        o_busy;
  logic        o_err;

  always #5 i_clk = ~i_clk;

  uart_boot_loader #(.TIMEOUT_CYC(100)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_ack  (i_mem_ack),
    .o_cpu_hold (o_cpu_hold),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  int pass_cnt = 0;
  int tot_cnt = 0;
  int ack_lat = 1;
  bit ack_en = 1'b1;
  int we_cnt = 0;

  logic [7:0]  frm[$];
  logic [31:0] win[$];
  logic [31:0] wa[$], wd[$];
  logic [31:0] ea[$], ed[$];
  bit exp_done, exp_err;

  // Memory side: ack ack_lat cycles after the request appears.
  always @(negedge i_clk) begin
    if (o_mem_we) we_cnt++;
    else we_cnt = 0;
    i_mem_ack = ack_en && o_mem_we && (we_cnt > ack_lat);
  end

  always @(posedge i_clk)
    if (!i_rst && o_mem_we && i_mem_ack) begin
      wa.push_back(o_mem_addr);
      wd.push_back(o_mem_wdata);
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic do_reset;
    i_rst = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data = '0;
    ack_en = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    wa.delete(); wd.delete();
    ea.delete(); ed.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit force_now);
    int n = 0;
    while (o_mem_we && !force_now && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 50) begin
      tot_cnt++;
      $display("FAIL ack_wait we stuck high got %0b want 0", o_mem_we);
    end
    i_rx_data = d;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i], 1'b0);
      if (i != frm.size() - 1)
        repeat ($urandom_range(max_gap, 0)) @(negedge i_clk);
    end
  endtask

  task automatic build(input logic [31:0] addr, input int n,
                       input logic [7:0] delta);
    logic [7:0] s;
    logic [31:0] w;
    logic [15:0] n16;
    s = 8'd0;
    n16 = 16'(n);
    frm.delete();
    frm.push_back(8'hA5);
    for (int i = 0; i < 4; i++) frm.push_back(addr[8*i +: 8]);
    frm.push_back(n16[7:0]);
    frm.push_back(n16[15:8]);
    for (int k = 0; k < n; k++) begin
      w = (k < win.size()) ? win[k] : $urandom();
      for (int i = 0; i < 4; i++) frm.push_back(w[8*i +: 8]);
    end
    for (int i = 1; i < frm.size(); i++) s = s + frm[i];
    frm.push_back(8'h00 - s + delta);
    win.delete();
  endtask

  // Expected writes and outcome of one frame, straight from the format.
  task automatic model;
    int s;
    int n;
    int b;
    logic [31:0] a;
    logic [7:0] sum;
    s = 0;
    sum = 8'd0;
    exp_done = 1'b0;
    exp_err = 1'b0;
    while (s < frm.size() && frm[s] != 8'hA5) s++;
    a = {frm[s+4], frm[s+3], frm[s+2], frm[s+1]};
    if (a % 4 != 0) begin
      exp_err = 1'b1;
      return;
    end
    n = int'({frm[s+6], frm[s+5]});
    for (int k = 0; k < n; k++) begin
      b = s + 7 + 4 * k;
      ea.push_back(32'(a + 32'(4 * k)));
      ed.push_back({frm[b+3], frm[b+2], frm[b+1], frm[b]});
    end
    for (int i = s + 1; i < frm.size(); i++) sum = sum + frm[i];
    if (sum == 8'd0) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    tot_cnt++; if (o_mem_we !== 1'b0) $display("FAIL rst_we got %0b want 0", o_mem_we); else pass_cnt++;
    tot_cnt++; if (o_mem_addr !== 32'd0) $display("FAIL rst_addr got %h want 0", o_mem_addr); else pass_cnt++;
    tot_cnt++; if (o_mem_wdata !== 32'd0) $display("FAIL rst_wdata got %h want 0", o_mem_wdata); else pass_cnt++;
    tot_cnt++; if (o_cpu_hold !== 1'b1) $display("FAIL rst_hold got %0b want 1", o_cpu_hold); else pass_cnt++;
    tot_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", o_busy); else pass_cnt++;
    tot_cnt++; if (o_err !== 1'b0) $display("FAIL rst_err got %0b want 0", o_err); else pass_cnt++;
  endtask

  task automatic test_valid_frame;
    do_reset();
    ack_lat = 1;
    win.push_back(32'h44332211);
    win.push_back(32'h88776655);
    build(32'h0000_0100, 2, 8'd0);
    send_frame(0);
    tot_cnt++; if (wa.size() != 2) $display("FAIL valid_nwr got %0d want 2", wa.size()); else pass_cnt++;
    if (wa.size() == 2) begin
      tot_cnt++; if (wa[0] !== 32'h100 || wd[0] !== 32'h44332211) $display("FAIL valid_wr0 got %h@%h want 44332211@00000100", wd[0], wa[0]); else pass_cnt++;
      tot_cnt++; if (wa[1] !== 32'h104 || wd[1] !== 32'h88776655) $display("FAIL valid_wr1 got %h@%h want 88776655@00000104", wd[1], wa[1]); else pass_cnt++;
    end
    tot_cnt++; if (o_cpu_hold !== 1'b0) $display("FAIL valid_hold got %0b want 0", o_cpu_hold); else pass_cnt++;
    tot_cnt++; if (o_err !== 1'b0) $display("FAIL valid_err got %0b want 0", o_err); else pass_cnt++;
    tot_cnt++; if (o_busy !== 1'b0) $display("FAIL valid_busy got %0b want 0", o_busy); else pass_cnt++;
    send_byte(8'hA5, 1'b0);
    tot_cnt++; if (o_busy !== 1'b0) $display("FAIL done_ignore got busy %0b want 0", o_busy); else pass_cnt++;
  endtask

  task automatic test_bad_csum;
    do_reset();
    ack_lat = 1;
    win.push_back(32'h44332211);
    win.push_back(32'h88776655);
    build(32'h0000_0100, 2, 8'd1);
    send_frame(0);
    tot_cnt++; if (wa.size() != 2) $display("FAIL badcs_nwr got %0d want 2", wa.size()); else pass_cnt++;
    if (wa.size() == 2) begin
      tot_cnt++; if (wd[1] !== 32'h88776655) $display("FAIL badcs_wr1 got %h want 88776655", wd[1]); else pass_cnt++;
    end
    tot_cnt++; if (o_err !== 1'b1) $display("FAIL badcs_err got %0b want 1", o_err); else pass_cnt++;
    tot_cnt++; if (o_cpu_hold !== 1'b1) $display("FAIL badcs_hold got %0b want 1", o_cpu_hold); else pass_cnt++;
  endtask

  task automatic test_garbage_len0;
    do_reset();
    frm.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b0);
    tot_cnt++; if (o_busy !== 1'b0) $display("FAIL garbage_busy got %0b want 0", o_busy); else pass_cnt++;
    build(32'h0, 0, 8'd0);
    tot_cnt++; if (frm[frm.size()-1] !== 8'h00) $display("FAIL len0_csum_byte got %h want 00", frm[frm.size()-1]); else pass_cnt++;
    send_frame(2);
    tot_cnt++; if (wa.size() != 0) $display("FAIL len0_nwr got %0d want 0", wa.size()); else pass_cnt++;
    tot_cnt++; if (o_cpu_hold !== 1'b0) $display("FAIL len0_hold got %0b want 0", o_cpu_hold); else pass_cnt++;
  endtask

  task automatic test_misaligned;
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    tot_cnt++; if (o_err !== 1'b0 || o_busy !== 1'b1) $display("FAIL misal_pre got err %0b busy %0b want 0 1", o_err, o_busy); else pass_cnt++;
    send_byte(8'h00, 1'b0);
    tot_cnt++; if (o_err !== 1'b1) $display("FAIL misal_err got %0b want 1", o_err); else pass_cnt++;
    tot_cnt++; if (o_busy !== 1'b0) $display("FAIL misal_busy got %0b want 0", o_busy); else pass_cnt++;
    repeat (4) send_byte(8'h00, 1'b0);
    tot_cnt++; if (wa.size() != 0 || o_mem_we !== 1'b0) $display("FAIL misal_nwr got %0d want 0", wa.size()); else pass_cnt++;
  endtask

  task automatic test_overrun;
    do_reset();
    ack_en = 1'b0;
    build(32'h0000_0200, 2, 8'd0);
    for (int i = 0; i < 11; i++) send_byte(frm[i], 1'b0);
    repeat (2) @(negedge i_clk);
    tot_cnt++; if (o_mem_we !== 1'b1) $display("FAIL ovr_req got %0b want 1", o_mem_we); else pass_cnt++;
    send_byte(8'h5A, 1'b1);
    tot_cnt++; if (o_mem_we !== 1'b0) $display("FAIL ovr_we got %0b want 0", o_mem_we); else pass_cnt++;
    tot_cnt++; if (o_err !== 1'b1 || o_cpu_hold !== 1'b1) $display("FAIL ovr_err got err %0b hold %0b want 1 1", o_err, o_cpu_hold); else pass_cnt++;
    tot_cnt++; if (wa.size() != 0) $display("FAIL ovr_nwr got %0d want 0", wa.size()); else pass_cnt++;
    ack_en = 1'b1;
    ack_lat = 2;
    build(32'h0000_0300, 1, 8'd0);
    model();
    send_frame(2);
    tot_cnt++; if (wa.size() != ea.size()) $display("FAIL ovr_next_nwr got %0d want %0d", wa.size(), ea.size()); else pass_cnt++;
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      tot_cnt++; if (wa[i] !== ea[i] || wd[i] !== ed[i]) $display("FAIL ovr_next_wr%0d got %h@%h want %h@%h", i, wd[i], wa[i], ed[i], ea[i]); else pass_cnt++;
    end
    tot_cnt++; if (o_cpu_hold !== 1'b0 || o_err !== 1'b0) $display("FAIL ovr_next_end got hold %0b err %0b want 0 0", o_cpu_hold, o_err); else pass_cnt++;
  endtask

  task automatic test_timeout;
    do_reset();
    build(32'h0, 1, 8'd0);
    for (int i = 0; i < 7; i++) send_byte(frm[i], 1'b0);
    repeat (99) @(posedge i_clk);
    #1;
    tot_cnt++; if (o_err !== 1'b0 || o_busy !== 1'b1) $display("FAIL tmo_early got err %0b busy %0b want 0 1", o_err, o_busy); else pass_cnt++;
    @(posedge i_clk);
    #1;
    tot_cnt++; if (o_err !== 1'b1 || o_busy !== 1'b0) $display("FAIL tmo_fire got err %0b busy %0b want 1 0", o_err, o_busy); else pass_cnt++;
    @(negedge i_clk);
  endtask

  task automatic test_random_frames;
    logic [31:0] r;
    int n;
    bit bad;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      ack_lat = $urandom_range(3, 0);
      r = $urandom();
      r[1:0] = 2'b00;
      if (it == 0) r = 32'hFFFF_FFFC;
      n = (it == 0) ? 2 : $urandom_range(4, 0);
      bad = ($urandom_range(1, 0) == 1);
      build(r, n, bad ? 8'($urandom_range(255, 1)) : 8'd0);
      model();
      send_frame(3);
      if (bad) begin
        tot_cnt++; if (o_err !== 1'b1) $display("FAIL rnd%0d_bad_err got %0b want 1", it, o_err); else pass_cnt++;
        r = $urandom();
        r[1:0] = 2'b00;
        build(r, $urandom_range(3, 1), 8'd0);
        model();
        send_frame(3);
      end
      tot_cnt++; if (wa.size() != ea.size()) $display("FAIL rnd%0d_nwr got %0d want %0d", it, wa.size(), ea.size()); else pass_cnt++;
      for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
        tot_cnt++; if (wa[i] !== ea[i] || wd[i] !== ed[i]) $display("FAIL rnd%0d_wr%0d got %h@%h want %h@%h", it, i, wd[i], wa[i], ed[i], ea[i]); else pass_cnt++;
      end
      tot_cnt++; if (o_cpu_hold !== !exp_done || o_err !== exp_err) $display("FAIL rnd%0d_end got hold %0b err %0b want %0b %0b", it, o_cpu_hold, o_err, !exp_done, exp_err); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_data;
    do_reset();
    ack_en = 1'b0;
    build(32'h0000_0400, 2, 8'd0);
    for (int i = 0; i < 9; i++) send_byte(frm[i], 1'b0);
    #2 i_rst = 1'b1;
    #1;
    tot_cnt++; if (o_mem_we !== 1'b0 || o_mem_addr !== 32'd0 || o_mem_wdata !== 32'd0) $display("FAIL midrst_mem got we %0b addr %h data %h want 0 0 0", o_mem_we, o_mem_addr, o_mem_wdata); else pass_cnt++;
    tot_cnt++; if (o_cpu_hold !== 1'b1 || o_busy !== 1'b0 || o_err !== 1'b0) $display("FAIL midrst_ctl got hold %0b busy %0b err %0b want 1 0 0", o_cpu_hold, o_busy, o_err); else pass_cnt++;
    @(negedge i_clk);
    i_rst = 1'b0;
    ack_en = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_csum();
    test_garbage_len0();
    test_misaligned();
    test_overrun();
    test_timeout();
    test_random_frames();
    test_reset_mid_data();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Receive-side controller that sequences the UART receiver's byte stream into a boot-load protocol. Frames are parsed from the received bytes, assembled into 32-bit little-endian words, and written through a single-beat memory write port into instruction/data RAM. The RISC-V core is held in reset until a frame passes its checksum. The block sits in the MMIO/UART area, between the UART receiver's byte/valid outputs and the RAM write port.

## Interface
- TIMEOUT_CYC, 5_000_000: maximum idle cycles between bytes inside a frame before aborting.
- SYNC_BYTE, 8'hA5: frame start marker.
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_data  in  8  received byte; valid only when i_rx_valid=1.
- i_rx_valid  in  1  one-cycle strobe per received byte.
- o_mem_we  out  1  write request; held until acknowledged.
- o_mem_addr  out  32  byte address, word aligned.
- o_mem_wdata  out  32  write data.
- i_mem_ack  in  1  write accepted in this cycle.
- o_cpu_hold  out  1  core reset hold.
- o_busy  out  1  frame in progress.
- o_err  out  1  last frame failed.

## Operation
- Frame format, little-endian: SYNC, ADDR[4], LEN[2] (count of 32-bit words), DATA[4*LEN], CSUM[1].
- Checksum: the mod-256 sum of every byte after SYNC, including CSUM, must equal 8'h00.
- States:
  - HUNT: bytes other than SYNC_BYTE are ignored. SYNC → ADDR; clear sum, byte index and o_err.
  - ADDR: after 4 bytes → LEN. If ADDR[1:0]≠0 → ERR.
  - LEN: after 2 bytes → DATA, or → CSUM if LEN=0.
  - DATA: on each 4th byte, latch the word, assert o_mem_we → WAIT_ACK.
  - WAIT_ACK: on i_mem_ack, address += 4 and remaining count −1; then → DATA, or → CSUM if the count reaches 0.
  - CSUM: sum==0 → DONE, else → ERR.
  - DONE: o_cpu_hold=0. Every byte is ignored until reset.
  - ERR: o_err=1, o_cpu_hold=1. Behaves as HUNT: a SYNC byte starts a new frame.
- Overrun: i_rx_valid in WAIT_ACK → ERR. Drop o_mem_we the same cycle as the transition; that word is not written.
- Timeout: an idle counter resets on every i_rx_valid. In ADDR/LEN/DATA/CSUM, a count reaching TIMEOUT_CYC → ERR. The counter does not run while in WAIT_ACK.
- Address wrap: addresses wrap modulo 2^32 with no error.
- Memory writes are not rolled back on a checksum failure; the core stays held.

## Timing
- Reset values: o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_cpu_hold=1, o_busy=0, o_err=0, state HUNT.
- Reset mid-frame aborts immediately; o_cpu_hold returns to 1.
- o_mem_we rises the cycle after the strobe of the 4th data byte of a word.
- o_mem_addr and o_mem_wdata are stable while o_mem_we=1.
- o_mem_we falls the cycle after i_mem_ack is sampled high. A same-cycle ack completes the write in 1 cycle.
- o_cpu_hold falls the cycle after a valid CSUM strobe.
- o_err rises the cycle after the error condition.
- o_busy=1 in ADDR, LEN, DATA, WAIT_ACK and CSUM.
- All outputs are registered.

## Structure
- Package uart_boot_pkg holds:
  - the state_t enum (HUNT, ADDR, LEN, DATA, WAIT_ACK, CSUM, DONE, ERR);
  - SYNC_BYTE default;
  - the frame field byte counts (ADDR_BYTES=4, LEN_BYTES=2).
- No sub-module; one flat always_ff FSM plus the idle counter.
- uart_rx is instantiated beside this block at the UART top level, not inside it.

## Test plan
- Frame A5, 00 01 00 00, 02 00, 11 22 33 44, 55 66 77 88, then a valid CSUM, with ack one cycle after each request:
  - writes 0x44332211 @0x00000100 and 0x88776655 @0x00000104;
  - o_cpu_hold falls; o_err=0.
- Same frame with the CSUM byte off by +1:
  - both writes occur;
  - ends in ERR; o_err=1; o_cpu_hold=1.
- Garbage 00 FF 12 followed by a valid LEN=0 frame (A5, 00 00 00 00, 00 00, CSUM 00):
  - garbage is ignored;
  - DONE is reached with no writes.
- ADDR 01 00 00 00 → ERR right after the 4th address byte; no write.
- i_mem_ack held low and a new data byte strobed during WAIT_ACK:
  - ERR; o_mem_we drops.
  - A following valid frame then succeeds.
- TIMEOUT_CYC=100 and the stream stops after LEN:
  - ERR exactly 100 cycles after the last strobe.
- Assert i_rst mid-DATA:
  - all outputs return to reset values within the same cycle.
